// File: rtl/ita_gelu_pkg.sv
// ita_gelu_pkg: shared widths, coefficient bundle and output saturation.
// Saturation is only used when ITA_GELU_SAT_EN is defined.
package ita_gelu_pkg;

   localparam int LanesDef = 4;
   localparam int DataWDef = 8;
   localparam int CoefWDef = 16;
   localparam int OutWDef  = 26;
   localparam int ProdWDef = DataWDef + OutWDef;

   typedef struct packed {
      logic signed [CoefWDef-1:0] b;
      logic signed [CoefWDef-1:0] c;
   } ita_gelu_coef_t;

   // Clamp a full-width lane product into the signed output range.
   function automatic logic [OutWDef-1:0] sat_to_out(
      input logic [ProdWDef-1:0] v
   );
      logic [ProdWDef-OutWDef:0] top;
      top = v[ProdWDef-1:OutWDef-1];
      if (&top || ~|top) begin
         return v[OutWDef-1:0];
      end
      return v[ProdWDef-1] ? {1'b1, {(OutWDef-1){1'b0}}}
                           : {1'b0, {(OutWDef-1){1'b1}}};
   endfunction

endpackage

// File: rtl/ita_gelu_lane.sv
// ita_gelu_lane: per-lane i-GELU datapath, S1 (abs/clip/square) and
// S2 (erf/sum/mul/reduce); ITA_GELU_SAT_EN selects saturating output.
module ita_gelu_lane
   import ita_gelu_pkg::*;
#(
   parameter int DATA_W = DataWDef,
   parameter int COEF_W = CoefWDef,
   parameter int OUT_W  = OutWDef
) (
   input  logic signed [DATA_W-1:0] s1X,
   input  logic signed [COEF_W-1:0] s1B,
   output logic        [OUT_W-1:0]  s1Sq,
   output logic                     s1Neg,
   input  logic signed [DATA_W-1:0] s2X,
   input  logic                     s2Neg,
   input  logic signed [OUT_W-1:0]  s2Sq,
   input  logic signed [COEF_W-1:0] s2C,
   output logic        [OUT_W-1:0]  s2Out
);

   logic signed [COEF_W-1:0] xExt;
   logic signed [COEF_W-1:0] absX;
   logic signed [COEF_W-1:0] negB;
   logic signed [COEF_W-1:0] clipK;
   logic signed [COEF_W-1:0] polyP;

   logic signed [OUT_W-1:0] cExt;
   logic signed [OUT_W-1:0] sumL;
   logic signed [OUT_W-1:0] erfE;
   logic signed [OUT_W-1:0] mulM;

   // S1: |x| in the wide path so -2^(DATA_W-1) is representable
   always_comb begin
      xExt  = COEF_W'(s1X);
      absX  = xExt[COEF_W-1] ? -xExt : xExt;
      negB  = -s1B;
      clipK = (absX < negB) ? absX : negB;
      polyP = clipK + s1B;
      s1Sq  = OUT_W'(polyP * polyP);
      s1Neg = s1X[DATA_W-1];
   end

`ifdef ITA_GELU_SAT_EN
   logic signed [DATA_W+OUT_W-1:0] prod;

   // S2: erf approximation, GELU sum and saturated product
   always_comb begin
      cExt  = OUT_W'(s2C);
      sumL  = s2Sq + cExt;
      erfE  = s2Neg ? -sumL : sumL;
      mulM  = erfE + cExt;
      prod  = (DATA_W+OUT_W)'(s2X) * (DATA_W+OUT_W)'(mulM);
      s2Out = sat_to_out(prod);
   end
`else
   // S2: erf approximation, GELU sum and wrapped product
   always_comb begin
      cExt  = OUT_W'(s2C);
      sumL  = s2Sq + cExt;
      erfE  = s2Neg ? -sumL : sumL;
      mulM  = erfE + cExt;
      s2Out = OUT_W'(OUT_W'(s2X) * mulM);
   end
`endif

endmodule

// File: rtl/ita_gelu_lanes.sv
// ita_gelu_lanes: LANES-wide elastic two-stage i-GELU pipeline.
// Define ITA_GELU_SAT_EN for saturating outputs (default wraps).
module ita_gelu_lanes
   import ita_gelu_pkg::*;
#(
   parameter int LANES  = LanesDef,
   parameter int DATA_W = DataWDef,
   parameter int COEF_W = CoefWDef,
   parameter int OUT_W  = OutWDef
) (
   input  logic                    io_clk,
   input  logic                    io_rst,
   input  logic                    cfg_we_i,
   input  logic [COEF_W-1:0]       cfg_b_i,
   input  logic [COEF_W-1:0]       cfg_c_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [LANES*DATA_W-1:0] in_data_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [LANES*OUT_W-1:0]  out_data_o
);

   ita_gelu_coef_t coefQ;

   logic v1Q;
   logic v2Q;
   logic en1;
   logic en2;

   logic [LANES*DATA_W-1:0] x1Q;
   logic [LANES*OUT_W-1:0]  sq1Q;
   logic [LANES*OUT_W-1:0]  sqD;
   logic [LANES*OUT_W-1:0]  outD;
   logic [LANES*OUT_W-1:0]  outQ;
   logic [LANES-1:0]        neg1Q;
   logic [LANES-1:0]        negD;
   logic [COEF_W-1:0]       c1Q;

   assign en2         = !v2Q || out_ready_i;
   assign en1         = !v1Q || en2;
   assign in_ready_o  = en1;
   assign out_valid_o = v2Q;
   assign out_data_o  = outQ;

   for (genvar g = 0; g < LANES; g++) begin : gLane
      ita_gelu_lane #(
         .DATA_W(DATA_W),
         .COEF_W(COEF_W),
         .OUT_W (OUT_W)
      ) uLane (
         .s1X  (in_data_i[g*DATA_W +: DATA_W]),
         .s1B  (COEF_W'(coefQ.b)),
         .s1Sq (sqD[g*OUT_W +: OUT_W]),
         .s1Neg(negD[g]),
         .s2X  (x1Q[g*DATA_W +: DATA_W]),
         .s2Neg(neg1Q[g]),
         .s2Sq (sq1Q[g*OUT_W +: OUT_W]),
         .s2C  (c1Q),
         .s2Out(outD[g*OUT_W +: OUT_W])
      );
   end

   // Coefficient register; a same-cycle accept still sees the old value
   always_ff @(posedge io_clk or posedge io_rst) begin
      if (io_rst) begin
         coefQ <= '0;
      end else if (cfg_we_i) begin
         coefQ <= '{b: cfg_b_i, c: cfg_c_i};
      end
   end

   // S1 register: square, sign, activation and c travel with the beat
   always_ff @(posedge io_clk or posedge io_rst) begin
      if (io_rst) begin
         v1Q   <= 1'b0;
         x1Q   <= '0;
         sq1Q  <= '0;
         neg1Q <= '0;
         c1Q   <= '0;
      end else if (en1) begin
         v1Q <= in_valid_i;
         if (in_valid_i) begin
            x1Q   <= in_data_i;
            sq1Q  <= sqD;
            neg1Q <= negD;
            c1Q   <= COEF_W'(coefQ.c);
         end
      end
   end

   // S2 register: output beat, held while downstream stalls
   always_ff @(posedge io_clk or posedge io_rst) begin
      if (io_rst) begin
         v2Q  <= 1'b0;
         outQ <= '0;
      end else if (en2) begin
         v2Q <= v1Q;
         if (v1Q) begin
            outQ <= outD;
         end
      end
   end

endmodule

// File: tb/tb_ita_gelu_lanes.sv
// tb_ita_gelu_lanes: directed and randomised checks of ita_gelu_lanes.
// Expected values are hand-derived or from a small wrap-aware model.
module tb_ita_gelu_lanes;

   localparam int LANES = 4;
   localparam int DW    = 8;
   localparam int CW    = 16;
   localparam int OW    = 26;
   localparam int NB    = 10000;

   logic                 clk;
   logic                 rst;
   logic                 cfgWe;
   logic [CW-1:0]        cfgB;
   logic [CW-1:0]        cfgC;
   logic                 inValid;
   logic                 inReady;
   logic [LANES*DW-1:0]  inData;
   logic                 outValid;
   logic                 outReady;
   logic [LANES*OW-1:0]  outData;

   int nChecks = 0;
   int nFails  = 0;

   logic [LANES*DW-1:0] inVec[5];
   logic [LANES*OW-1:0] outVec[5];

   ita_gelu_lanes dut (
      .io_clk     (clk),
      .io_rst     (rst),
      .cfg_we_i   (cfgWe),
      .cfg_b_i    (cfgB),
      .cfg_c_i    (cfgC),
      .in_valid_i (inValid),
      .in_ready_o (inReady),
      .in_data_i  (inData),
      .out_valid_o(outValid),
      .out_ready_i(outReady),
      .out_data_o (outData)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [LANES*DW-1:0] packIn(
      input int x0, input int x1, input int x2, input int x3
   );
      return {DW'(x3), DW'(x2), DW'(x1), DW'(x0)};
   endfunction

   function automatic logic [LANES*OW-1:0] packOut(
      input longint y0, input longint y1, input longint y2, input longint y3
   );
      return {OW'(y3), OW'(y2), OW'(y1), OW'(y0)};
   endfunction

   function automatic longint wrapS(input longint v, input int w);
      longint m;
      m = v & ((longint'(1) << w) - 1);
      if (m >= (longint'(1) << (w - 1))) m = m - (longint'(1) << w);
      return m;
   endfunction

   function automatic longint refLane(input int x, input int b, input int c);
      longint a, k, p, sq, l, e, m, pr, lim;
      a  = (x < 0) ? -x : x;
      k  = (a < -b) ? a : -b;
      p  = wrapS(k + b, CW);
      sq = wrapS(p * p, OW);
      l  = wrapS(sq + c, OW);
      e  = (x < 0) ? wrapS(-l, OW) : l;
      m  = wrapS(e + c, OW);
      pr = longint'(x) * m;
      lim = longint'(1) << (OW - 1);
`ifdef ITA_GELU_SAT_EN
      if (pr > lim - 1) return lim - 1;
      if (pr < -lim) return -lim;
      return pr;
`else
      return wrapS(pr, OW);
`endif
   endfunction

   function automatic logic [LANES*OW-1:0] refBeat(
      input logic [LANES*DW-1:0] d, input int b, input int c
   );
      logic [LANES*OW-1:0] r;
      logic signed [DW-1:0] t;
      r = '0;
      for (int i = 0; i < LANES; i++) begin
         t = d[i*DW +: DW];
         r[i*OW +: OW] = OW'(refLane(int'(t), b, c));
      end
      return r;
   endfunction

   task automatic setCfg(input int b, input int c);
      inValid = 1'b0;
      cfgWe   = 1'b1;
      cfgB    = CW'(b);
      cfgC    = CW'(c);
      @(posedge clk); #1;
      cfgWe   = 1'b0;
   endtask

   task automatic test_reset;
      rst      = 1'b1;
      cfgWe    = 1'b0;
      cfgB     = '0;
      cfgC     = '0;
      inValid  = 1'b0;
      inData   = '0;
      outReady = 1'b1;
      #1;
      nChecks++;
      if (outValid !== 1'b0) begin
         nFails++;
         $display("FAIL reset_valid got %b exp 0", outValid);
      end
      nChecks++;
      if (outData !== '0) begin
         nFails++;
         $display("FAIL reset_data got %h exp 0", outData);
      end
      nChecks++;
      if (inReady !== 1'b1) begin
         nFails++;
         $display("FAIL reset_ready got %b exp 1", inReady);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      nChecks++;
      if (outValid !== 1'b0) begin
         nFails++;
         $display("FAIL post_reset_valid got %b exp 0", outValid);
      end
   endtask

   task automatic test_basic;
      setCfg(-8, 4);
      inData   = packIn(3, -3, 20, -128);
      inValid  = 1'b1;
      outReady = 1'b1;
      #1;
      nChecks++;
      if (inReady !== 1'b1) begin
         nFails++;
         $display("FAIL basic_ready got %b exp 1", inReady);
      end
      @(posedge clk); #1;
      inValid = 1'b0;
      nChecks++;
      if (outValid !== 1'b0) begin
         nFails++;
         $display("FAIL basic_latency1 got %b exp 0", outValid);
      end
      @(posedge clk); #1;
      nChecks++;
      if (outValid !== 1'b1) begin
         nFails++;
         $display("FAIL basic_latency2 got %b exp 1", outValid);
      end
      nChecks++;
      if (outData !== packOut(99, 75, 160, 0)) begin
         nFails++;
         $display("FAIL basic_data got %h exp %h",
                  outData, packOut(99, 75, 160, 0));
      end
      @(posedge clk); #1;
      nChecks++;
      if (outValid !== 1'b0) begin
         nFails++;
         $display("FAIL basic_drain got %b exp 0", outValid);
      end
   endtask

   task automatic test_cfg_same_cycle;
      inData   = packIn(3, 3, 3, 3);
      inValid  = 1'b1;
      outReady = 1'b1;
      cfgWe    = 1'b1;
      cfgB     = CW'(-4);
      cfgC     = CW'(0);
      @(posedge clk); #1;
      cfgWe = 1'b0;
      @(posedge clk); #1;
      inValid = 1'b0;
      nChecks++;
      if (outValid !== 1'b1 || outData !== packOut(99, 99, 99, 99)) begin
         nFails++;
         $display("FAIL cfg_old_coef got v=%b %h exp %h",
                  outValid, outData, packOut(99, 99, 99, 99));
      end
      @(posedge clk); #1;
      nChecks++;
      if (outValid !== 1'b1 || outData !== packOut(3, 3, 3, 3)) begin
         nFails++;
         $display("FAIL cfg_new_coef got v=%b %h exp %h",
                  outValid, outData, packOut(3, 3, 3, 3));
      end
      @(posedge clk); #1;
   endtask

   task automatic test_sat;
      logic [LANES*OW-1:0] exp;
      setCfg(-32767, 32767);
`ifdef ITA_GELU_SAT_EN
      exp = packOut(-33554432, -65534, 0, 0);
`else
      exp = packOut(18792194, -65534, 0, 0);
`endif
      inData   = packIn(127, 1, 0, 0);
      inValid  = 1'b1;
      outReady = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      @(posedge clk); #1;
      nChecks++;
      if (outValid !== 1'b1 || outData !== exp) begin
         nFails++;
         $display("FAIL sat_range got v=%b %h exp %h", outValid, outData, exp);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      int idx, rx, guard;
      bit acc, xfer;
      setCfg(-8, 4);
      idx = 0;
      rx  = 0;
      outReady = 1'b0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         inValid = 1'b1;
         inData  = inVec[idx];
         #1;
         acc = inReady;
         if (outValid) begin
            nChecks++;
            if (outData !== outVec[0]) begin
               nFails++;
               $display("FAIL stall_hold got %h exp %h", outData, outVec[0]);
            end
         end
         @(posedge clk); #1;
         if (acc) idx++;
      end
      nChecks++;
      if (idx != 2) begin
         nFails++;
         $display("FAIL stall_accepts got %0d exp 2", idx);
      end
      nChecks++;
      if (inReady !== 1'b0) begin
         nFails++;
         $display("FAIL stall_ready got %b exp 0", inReady);
      end
      outReady = 1'b1;
      guard = 0;
      while (rx < 5 && guard < 40) begin
         inValid = (idx < 5);
         if (idx < 5) inData = inVec[idx];
         #1;
         acc  = inValid && inReady;
         xfer = outValid;
         if (idx < 5) begin
            nChecks++;
            if (inReady !== 1'b1) begin
               nFails++;
               $display("FAIL stream_ready got %b exp 1", inReady);
            end
         end
         if (xfer) begin
            nChecks++;
            if (outData !== outVec[rx]) begin
               nFails++;
               $display("FAIL stream_beat%0d got %h exp %h",
                        rx, outData, outVec[rx]);
            end
         end
         @(posedge clk); #1;
         if (acc) idx++;
         if (xfer) rx++;
         guard++;
      end
      inValid = 1'b0;
      nChecks++;
      if (rx != 5) begin
         nFails++;
         $display("FAIL stream_count got %0d exp 5", rx);
      end
      #1;
      nChecks++;
      if (outValid !== 1'b0) begin
         nFails++;
         $display("FAIL stream_dup got %b exp 0", outValid);
      end
   endtask

   task automatic test_reset_midflight;
      setCfg(-8, 4);
      outReady = 1'b0;
      inValid  = 1'b1;
      inData   = inVec[1];
      @(posedge clk); #1;
      inData   = inVec[2];
      @(posedge clk); #1;
      inValid  = 1'b0;
      nChecks++;
      if (outValid !== 1'b1 || inReady !== 1'b0) begin
         nFails++;
         $display("FAIL flight_full got v=%b r=%b exp v=1 r=0",
                  outValid, inReady);
      end
      #2;
      rst = 1'b1;
      @(posedge clk); #1;
      nChecks++;
      if (outValid !== 1'b0 || outData !== '0 || inReady !== 1'b1) begin
         nFails++;
         $display("FAIL flight_reset got v=%b d=%h r=%b exp 0/0/1",
                  outValid, outData, inReady);
      end
      rst = 1'b0;
      outReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         nChecks++;
         if (outValid !== 1'b0) begin
            nFails++;
            $display("FAIL flight_stale cycle %0d got %b exp 0", i, outValid);
         end
      end
   endtask

   task automatic test_random;
      logic [LANES*OW-1:0] expQ[$];
      logic [LANES*OW-1:0] exp;
      int sent, rx, guard;
      bit acc, xfer;
      setCfg(-100, 37);
      sent  = 0;
      rx    = 0;
      guard = 0;
      inData = $urandom;
      while (rx < NB && guard < 60000) begin
         inValid  = (sent < NB) && ($urandom_range(0, 3) != 0);
         outReady = ($urandom_range(0, 3) != 0);
         #1;
         acc  = inValid && inReady;
         xfer = outValid && outReady;
         if (xfer) begin
            nChecks++;
            if (expQ.size() == 0) begin
               nFails++;
               $display("FAIL rand_extra beat got %h exp none", outData);
            end else begin
               exp = expQ.pop_front();
               if (outData !== exp) begin
                  nFails++;
                  $display("FAIL rand_beat%0d got %h exp %h", rx, outData, exp);
               end
            end
            rx++;
         end
         if (acc) begin
            expQ.push_back(refBeat(inData, -100, 37));
            sent++;
         end
         @(posedge clk); #1;
         if (acc) inData = $urandom;
         guard++;
      end
      inValid = 1'b0;
      nChecks++;
      if (rx != NB || expQ.size() != 0) begin
         nFails++;
         $display("FAIL rand_count got %0d left %0d exp %0d left 0",
                  rx, expQ.size(), NB);
      end
   endtask

   initial begin
      inVec[0]  = packIn(3, -3, 20, -128);
      outVec[0] = packOut(99, 75, 160, 0);
      inVec[1]  = packIn(1, -1, 5, -5);
      outVec[1] = packOut(57, 49, 85, 45);
      inVec[2]  = packIn(8, 127, 0, 2);
      outVec[2] = packOut(64, 1016, 0, 88);
      inVec[3]  = packIn(-2, -20, 3, 1);
      outVec[3] = packOut(72, 0, 99, 57);
      inVec[4]  = packIn(-3, -1, -5, -2);
      outVec[4] = packOut(75, 49, 45, 72);

      test_reset();
      test_basic();
      test_cfg_same_cycle();
      test_sat();
      test_back_to_back();
      test_reset_midflight();
      test_random();

      $display("End of test - %0d assertions evaluated, %0d failures",
               nChecks, nFails);
      $finish;
   end

endmodule
